// File: rtl/byte_sub_serial.sv
// Bit-serial (s - a) mod 2^W using one full-subtractor cell, valid/ready on both sides.
// Define BYTE_SUB_SERIAL_BORROW_EN to expose the final borrow on borrow_out.
`timescale 1ns/1ps
module byte_sub_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] a_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] b_out,
`ifdef BYTE_SUB_SERIAL_BORROW_EN
  output logic         borrow_out,
`endif
  output logic         busy,
  output logic [1:0]   state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so the two never coincide.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  logic [W-1:0]  sreg;
  logic [W-1:0]  areg;
  logic [W-1:0]  breg;
  logic          br;
  logic [CW-1:0] cnt;
  logic          idle_q;
  logic          diff_bit;
  logic          br_next;

  always_comb begin
    diff_bit = sreg[0] ^ areg[0] ^ br;
    br_next  = (~sreg[0] & areg[0]) | (~(sreg[0] ^ areg[0]) & br);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      areg      <= '0;
      breg      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg   <= s_in;
            areg   <= a_in;
            br     <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
            busy   <= 1'b1;
            idle_q <= 1'b0;
          end
        end
        SHIFT: begin
          // LSB first; each result bit enters at the top so breg is aligned after W shifts.
          breg <= {diff_bit, breg[W-1:1]};
          sreg <= sreg >> 1;
          areg <= areg >> 1;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            idle_q    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          idle_q    <= 1'b1;
        end
      endcase
    end
  end

  // Reset masks in_ready immediately so nothing is accepted while rst_n is low.
  assign in_ready  = idle_q & rst_n;
  assign b_out     = breg;
  assign state_dbg = state;
`ifdef BYTE_SUB_SERIAL_BORROW_EN
  assign borrow_out = br;
`endif

endmodule

// File: tb/tb_byte_sub_serial.sv
// Scoreboard bench for byte_sub_serial: W=8 directed cases plus a W=4 streaming instance.
`timescale 1ns/1ps
module tb_byte_sub_serial;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0] s8, a8, b8;
  logic [1:0] st8;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0] s4, a4, b4;
  logic [1:0] st4;
`ifdef BYTE_SUB_SERIAL_BORROW_EN
  logic borrow8, borrow4;
`endif

  byte_sub_serial #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .s_in(s8), .a_in(a8), .out_valid(out_valid8), .out_ready(out_ready8),
    .b_out(b8),
`ifdef BYTE_SUB_SERIAL_BORROW_EN
    .borrow_out(borrow8),
`endif
    .busy(busy8), .state_dbg(st8)
  );

  byte_sub_serial #(.W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .s_in(s4), .a_in(a4), .out_valid(out_valid4), .out_ready(out_ready4),
    .b_out(b4),
`ifdef BYTE_SUB_SERIAL_BORROW_EN
    .borrow_out(borrow4),
`endif
    .busy(busy4), .state_dbg(st4)
  );

  // scoreboard: {borrow, difference}
  logic [8:0] exp_q8[$];
  logic [4:0] exp_q4[$];
  int         t4[$];
  int         errors = 0;
  int         checks = 0;
  int         acc8 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon8();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (out_valid8 && out_ready8) begin
        if (exp_q8.size() == 0) check("unexpected_out8", 1, 0);
        else begin
          e = exp_q8.pop_front();
          check("b_out8", b8, e[7:0]);
`ifdef BYTE_SUB_SERIAL_BORROW_EN
          check("borrow8", borrow8, e[8]);
`endif
        end
      end
    end
  endtask

  task automatic mon4();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (out_valid4 && out_ready4) begin
        t4.push_back(cyc);
        if (exp_q4.size() == 0) check("unexpected_out4", 1, 0);
        else begin
          e = exp_q4.pop_front();
          check("b_out4", b4, e[3:0]);
`ifdef BYTE_SUB_SERIAL_BORROW_EN
          check("borrow4", borrow4, e[4]);
`endif
        end
      end
    end
  endtask

  // driver tasks
  task automatic send8(input logic [7:0] s, input logic [7:0] a, input bit push);
    logic [7:0] d;
    int n;
    @(posedge clk); #1;
    in_valid8 = 1'b1; s8 = s; a8 = a;
    d = s - a;
    if (push) exp_q8.push_back({(s < a), d});
    n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout8", 1, 0);
    acc8 = cyc;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] s, input logic [3:0] a);
    logic [3:0] d;
    int n;
    @(posedge clk); #1;
    in_valid4 = 1'b1; s4 = s; a4 = a;
    d = s - a;
    exp_q4.push_back({(s < a), d});
    n = 0;
    @(negedge clk);
    while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout4", 1, 0);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic wait_ov8(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("out_valid_timeout8", 1, 0);
    c = cyc;
  endtask

  initial begin
    int c;
    int seen;
    rst_n = 1'b0;
    in_valid8 = 1'b0; s8 = '0; a8 = '0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; s4 = '0; a4 = '0; out_ready4 = 1'b1;
    fork
      mon8();
      mon4();
    join_none

    // reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready8, 0);
    check("rst_out_valid", out_valid8, 0);
    check("rst_b_out", b8, 0);
    check("rst_busy", busy8, 0);
`ifdef BYTE_SUB_SERIAL_BORROW_EN
    check("rst_borrow", borrow8, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready8, 1);
    check("rel_busy", busy8, 0);
    check("rel_in_ready4", in_ready4, 1);

    // basic: out_valid appears 9 cycles after the accept cycle
    send8(8'h5A, 8'h23, 1);
    wait_ov8(c);
    check("latency", c - acc8, 9);

    // wrap-around
    send8(8'h00, 8'h01, 1);
    wait_ov8(c);
    send8(8'hFF, 8'hFF, 1);
    wait_ov8(c);

    // backpressure: DONE held for 5 cycles
    @(posedge clk); #1 out_ready8 = 1'b0;
    send8(8'h80, 8'h01, 1);
    wait_ov8(c);
    for (int i = 0; i < 5; i++) begin
      check("bp_b_out", b8, 8'h7F);
      check("bp_in_ready", in_ready8, 0);
      check("bp_out_valid", out_valid8, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready8, 1);

    // reset pulse while cnt = 3; the operation must be dropped
    send8(8'h33, 8'h11, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready8, 1);
    check("midrst_busy", busy8, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) seen++;
      @(negedge clk);
    end
    check("midrst_no_out_valid", seen, 0);
    send8(8'h10, 8'h01, 1);
    wait_ov8(c);

    // W=4 back-to-back stream
    send4(4'h3, 4'h5);
    send4(4'hE, 4'h7);
    send4(4'h0, 4'h0);

    for (int i = 0; i < 60 && (exp_q4.size() != 0 || exp_q8.size() != 0); i++)
      @(negedge clk);
    check("q8_drained", exp_q8.size(), 0);
    check("q4_drained", exp_q4.size(), 0);
    check("w4_result_count", t4.size(), 3);
    if (t4.size() == 3) begin
      check("w4_spacing_1", t4[1] - t4[0], 6);
      check("w4_spacing_2", t4[2] - t4[1], 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
